mdu_seq: RTL
============

Name: mdu_seq

Overview:
- Iterative multiply unit sitting downstream of the instruction decoder, in the execute stage beside the ALU.
- Executes multu/mult into the HI/LO register pair. Services mthi/mtlo writes and provides HI/LO for mfhi/mflo.
- Radix-2 shift-add core, one partial product per cycle. The datapath stalls instruction issue while busy is high.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle request to begin a multiply
- sgn  input  1  0 = multu (unsigned), 1 = mult (two's complement); sampled with start
- a  input  WIDTH  multiplicand (rs); sampled with start
- b  input  WIDTH  multiplier (rt); sampled with start
- hi_we  input  1  mthi write enable
- lo_we  input  1  mtlo write enable
- wdata  input  WIDTH  mthi/mtlo write data
- busy  output  1  multiply in progress
- done  output  1  one-cycle pulse: HI/LO were just updated by a multiply
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Reset (reset_n low, asynchronous): state IDLE; busy=0, done=0, hi=0, lo=0; all internal registers cleared.
- Reset mid-operation aborts the multiply. No partial result ever reaches hi/lo.
- States: IDLE, RUN, FIN.
- IDLE to RUN: start=1 at edge E0.
  - Latch neg = sgn & (a[W-1] ^ b[W-1]).
  - Latch the magnitudes |a| and |b|. When sgn=0 the operands are taken as-is.
  - Clear the 2W-bit accumulator and load the iteration counter with WIDTH.
  - busy=1 from E0.
- Magnitude rule: the most negative value (0x80000000) has magnitude 2^(W-1), which is representable in W unsigned bits. No overflow case exists.
- RUN: on each edge, if the multiplier LSB is 1, add the multiplicand into the upper half of the accumulator.
  - The add is W+1 bits wide and keeps the carry.
  - Then shift {carry, acc} right by one and decrement the counter.
  - After exactly WIDTH RUN edges (E1..EW), go to FIN.
- FIN (edge E(W+1)):
  - {hi, lo} <= neg ? -acc : acc (2W-bit two's complement negate).
  - done=1 for exactly this following cycle; busy=0; return to IDLE.
- Latency: start at E0 gives hi/lo valid and done high after E(W+1), i.e. W+1 cycles. busy is high for W+1 cycles.
- hi/lo hold their previous values throughout RUN; the accumulator is internal. mfhi/mflo issued while busy read stale values, so the datapath must stall on busy.
- start while busy: ignored; the operation in flight continues unaffected.
- hi_we/lo_we while busy: ignored, no write.
- hi_we/lo_we in IDLE with start=0: the register is written on the next edge. Both enables high writes wdata to both registers.
- start and hi_we/lo_we in the same IDLE cycle: start wins; the write is dropped.
- Writes in the FIN cycle are ignored because busy is still high.
- done and busy are never both high.
- No unknown values: all outputs are driven from registers.

Test Plan:
- Reset then idle: reset_n pulse low → hi=0, lo=0, busy=0, done=0.
  - hi_we=1, wdata=0x12345678 → hi=0x12345678 after one edge, lo unchanged.
- multu a=0xFFFFFFFF, b=0xFFFFFFFF:
  - busy high for 33 cycles.
  - done pulse → hi=0xFFFFFFFE, lo=0x00000001.
- mult signed, a=0xFFFFFFFD (-3), b=5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1.
  - a=0xFFFFFFFF, b=0xFFFFFFFF → hi=0, lo=1.
- mult a=0x80000000, b=0x80000000 → hi=0x40000000, lo=0.
  - The same operands with multu → hi=0x40000000, lo=0.
- Interference during a multu 7×6:
  - Assert start (a=9, b=9) and lo_we (wdata=0xDEAD) at cycle 5 → both ignored.
  - Result hi=0, lo=42.
  - Start in the same cycle as lo_we from IDLE → multiply runs and the write is dropped.
- Reset mid-operation:
  - Preload hi=0xAAAA via mthi, start multu 3×3, drop reset_n at cycle 10 → busy=0, hi=0, lo=0, and no done pulse.
  - Next start 3×3 → lo=9 after 33 cycles.

Source files
------------

// File: rtl/mdu_seq.sv
// mdu_seq: iterative HI/LO multiply unit for the execute stage.
//
// Runs multu/mult as a radix-2 shift-add loop with one partial product per
// cycle, then writes the 2*WIDTH-bit product into HI/LO. It also takes
// mthi/mtlo writes, and HI/LO are presented directly for mfhi/mflo.
//
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   start    one-cycle multiply request (accepted only in IDLE)
//   sgn      0 = multu, 1 = mult; sampled with start
//   a, b     multiplicand / multiplier; sampled with start
//   hi_we    mthi write enable (IDLE only, loses to start)
//   lo_we    mtlo write enable (IDLE only, loses to start)
//   wdata    mthi/mtlo write data
//   busy     multiply in progress; issue must stall while high
//   done     one-cycle pulse after HI/LO take a multiply result
//   hi, lo   HI/LO registers
//
// State | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting; accepts start or mthi/mtlo writes
// RUN   | WIDTH shift-add iterations on the internal accumulator
// FIN   | apply sign to the accumulator and write HI/LO
module mdu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             sgn,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int DW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              neg_q, neg_d;
    logic [WIDTH-1:0]  mcand_q, mcand_d;
    logic [WIDTH-1:0]  mplier_q, mplier_d;
    logic [DW-1:0]     acc_q, acc_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  hi_q, hi_d;
    logic [WIDTH-1:0]  lo_q, lo_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [WIDTH-1:0]  a_mag;
    logic [WIDTH-1:0]  b_mag;
    logic [WIDTH:0]    psum;
    logic [DW-1:0]     acc_neg;

    // Negating 0x80..0 yields 0x80..0, which is exactly its magnitude when
    // the result is read as unsigned, so no overflow handling is needed.
    always_comb begin
        a_mag = (sgn && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
        b_mag = (sgn && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
    end

    // The add keeps its carry so the subsequent right shift never loses it.
    always_comb begin
        psum = {1'b0, acc_q[DW-1:WIDTH]};
        if (mplier_q[0]) begin
            psum = {1'b0, acc_q[DW-1:WIDTH]} + {1'b0, mcand_q};
        end
        acc_neg = ~acc_q + DW'(1);
    end

    always_comb begin
        state_d  = state_q;
        neg_d    = neg_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = RUN;
                    neg_d    = sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
                    mcand_d  = a_mag;
                    mplier_d = b_mag;
                    acc_d    = '0;
                    cnt_d    = CW'(WIDTH);
                end else begin
                    if (hi_we) hi_d = wdata;
                    if (lo_we) lo_d = wdata;
                end
            end
            RUN: begin
                acc_d    = {psum, acc_q[WIDTH-1:1]};
                mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
                cnt_d    = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                {hi_d, lo_d} = neg_q ? acc_neg : acc_q;
                done_d       = 1'b1;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            neg_q    <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            neg_q    <= neg_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
